// File: rtl/rob_entry_structs.sv
// ----------------------------------------------------------------------------
// rob_entry_structs
//   Shared types and widths between the ROB and the architectural register
//   file. rob_to_regfile is the commit bus the ROB drives into commit_regfile.
//   Widths live here so both ends of the bus agree.
// ----------------------------------------------------------------------------
package rob_entry_structs;

   localparam int NUM_ARCH_REGS = 32;
   localparam int ROB_IDX_W     = 5;
   localparam int XLEN          = 32;
   localparam int REG_IDX_W     = 5;

   // Commit bus, MSB first: {valid, value, rob_idx, regfile_idx}
   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      value;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [REG_IDX_W-1:0] regfile_idx;
   } rob_to_regfile;

   localparam int ROB_TO_REGFILE_W = $bits(rob_to_regfile);

   // Where a read port sources its value from this cycle
   typedef enum logic [1:0] {
      RD_SRC_ZERO = 2'd0,   // x0 or out-of-range index
      RD_SRC_FWD  = 2'd1,   // same-cycle commit to the same register
      RD_SRC_REG  = 2'd2    // registered state
   } rd_src_e;

   // True when idx names a real register. Register 0 counts as in range;
   // callers handle x0 separately.
   function automatic logic reg_in_range(input logic [REG_IDX_W-1:0] idx,
                                         input int num_regs);
      return (int'(idx) < num_regs);
   endfunction

endpackage

// File: rtl/commit_regfile_rdport.sv
// ----------------------------------------------------------------------------
// commit_regfile_rdport
//   One combinational read port of commit_regfile. Looks up value/busy/tag
//   for rd_idx from the registered state and forwards a same-cycle commit to
//   the same register so write-to-read latency is zero.
// Ports
//   regs, busy, tags  registered state arrays of the register file
//   commit_i          ROB commit bus (rob_to_regfile, packed)
//   rd_idx            register to read
//   rd_value          value (forwarded when the register is committing)
//   rd_busy           1 = value still pending in ROB entry rd_tag
//   rd_tag            stored ROB tag for rd_idx
// ----------------------------------------------------------------------------
module commit_regfile_rdport #(
   parameter int NUM_REGS  = 32,
   parameter int ROB_IDX_W = 5,
   parameter int XLEN      = 32
) (
   input  logic [NUM_REGS-1:0][XLEN-1:0]                  regs,
   input  logic [NUM_REGS-1:0]                            busy,
   input  logic [NUM_REGS-1:0][ROB_IDX_W-1:0]             tags,
   input  logic [rob_entry_structs::ROB_TO_REGFILE_W-1:0] commit_i,
   input  logic [4:0]                                     rd_idx,
   output logic [XLEN-1:0]                                rd_value,
   output logic                                           rd_busy,
   output logic [ROB_IDX_W-1:0]                           rd_tag
);
   import rob_entry_structs::*;

   rob_to_regfile cm;
   rd_src_e       src;

   assign cm = rob_to_regfile'(commit_i);

   always_comb begin
      src = RD_SRC_ZERO;
      if (rd_idx != 5'd0 && reg_in_range(rd_idx, NUM_REGS)) begin
         if (cm.valid && cm.regfile_idx == rd_idx) src = RD_SRC_FWD;
         else                                      src = RD_SRC_REG;
      end
   end

   // A forwarded commit only clears busy when it is the producer the rename
   // table is waiting for; an older (stale) producer leaves the register busy.
   always_comb begin
      rd_value = '0;
      rd_busy  = 1'b0;
      rd_tag   = '0;
      case (src)
         RD_SRC_FWD: begin
            rd_value = cm.value;
            rd_busy  = busy[rd_idx] && (tags[rd_idx] != cm.rob_idx);
            rd_tag   = tags[rd_idx];
         end
         RD_SRC_REG: begin
            rd_value = regs[rd_idx];
            rd_busy  = busy[rd_idx];
            rd_tag   = tags[rd_idx];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/commit_regfile.sv
// ----------------------------------------------------------------------------
// commit_regfile
//   Architectural register file with per-register rename status (busy + ROB
//   tag). Committed values arrive on the ROB commit bus; dispatch marks
//   destinations busy at issue; a flush discards all rename state.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   commit_i                     rob_to_regfile {valid,value,rob_idx,regfile_idx}
//   issue_valid/issue_rd/
//   issue_rob_idx                dispatch rename of issue_rd to issue_rob_idx
//   flush                        mispredict flush: clears all busy/tags
//   rs1_*/rs2_*                  two combinational read ports
//   retired_cnt                  valid commits since reset (wraps)
// ----------------------------------------------------------------------------
module commit_regfile #(
   parameter int NUM_REGS  = rob_entry_structs::NUM_ARCH_REGS,
   parameter int ROB_IDX_W = rob_entry_structs::ROB_IDX_W,
   parameter int XLEN      = rob_entry_structs::XLEN
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [rob_entry_structs::ROB_TO_REGFILE_W-1:0] commit_i,
   input  logic                                           issue_valid,
   input  logic [4:0]                                     issue_rd,
   input  logic [ROB_IDX_W-1:0]                           issue_rob_idx,
   input  logic                                           flush,
   input  logic [4:0]                                     rs1_idx,
   output logic [XLEN-1:0]                                rs1_value,
   output logic                                           rs1_busy,
   output logic [ROB_IDX_W-1:0]                           rs1_tag,
   input  logic [4:0]                                     rs2_idx,
   output logic [XLEN-1:0]                                rs2_value,
   output logic                                           rs2_busy,
   output logic [ROB_IDX_W-1:0]                           rs2_tag,
   output logic [31:0]                                    retired_cnt
);
   import rob_entry_structs::*;

   localparam int NUM_RD = 2;

   logic [NUM_REGS-1:0][XLEN-1:0]      regs;
   logic [NUM_REGS-1:0]                busy;
   logic [NUM_REGS-1:0][ROB_IDX_W-1:0] tags;

   rob_to_regfile cm;
   logic          cm_wr;
   logic          iss_wr;

   assign cm = rob_to_regfile'(commit_i);

   // x0 and out-of-range registers are never written or renamed
   assign cm_wr  = cm.valid && cm.regfile_idx != 5'd0
                   && reg_in_range(cm.regfile_idx, NUM_REGS);
   assign iss_wr = issue_valid && !flush && issue_rd != 5'd0
                   && reg_in_range(issue_rd, NUM_REGS);

   // Later assignments to busy/tags deliberately override earlier ones:
   // issue beats commit on the status fields, flush beats both.
   always_ff @(posedge clk) begin
      if (rst) begin
         regs        <= '0;
         busy        <= '0;
         tags        <= '0;
         retired_cnt <= '0;
      end else begin
         if (cm.valid) retired_cnt <= retired_cnt + 32'd1;
         if (cm_wr) begin
            regs[cm.regfile_idx] <= cm.value;
            if (tags[cm.regfile_idx] == cm.rob_idx) busy[cm.regfile_idx] <= 1'b0;
         end
         if (flush) begin
            busy <= '0;
            tags <= '0;
         end else if (iss_wr) begin
            busy[issue_rd] <= 1'b1;
            tags[issue_rd] <= issue_rob_idx;
         end
      end
   end

   // ---- read ports ----
   logic [NUM_RD-1:0][4:0]           rd_idx;
   logic [NUM_RD-1:0][XLEN-1:0]      rd_value;
   logic [NUM_RD-1:0]                rd_busy;
   logic [NUM_RD-1:0][ROB_IDX_W-1:0] rd_tag;

   assign rd_idx = {rs2_idx, rs1_idx};

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      commit_regfile_rdport #(
         .NUM_REGS  (NUM_REGS),
         .ROB_IDX_W (ROB_IDX_W),
         .XLEN      (XLEN)
      ) u_rdport (
         .regs     (regs),
         .busy     (busy),
         .tags     (tags),
         .commit_i (commit_i),
         .rd_idx   (rd_idx[p]),
         .rd_value (rd_value[p]),
         .rd_busy  (rd_busy[p]),
         .rd_tag   (rd_tag[p])
      );
   end

   assign rs1_value = rd_value[0];
   assign rs1_busy  = rd_busy[0];
   assign rs1_tag   = rd_tag[0];
   assign rs2_value = rd_value[1];
   assign rs2_busy  = rd_busy[1];
   assign rs2_tag   = rd_tag[1];

endmodule
